// File: rtl/if_pkg.sv
// Shared defaults and the prefetch-queue entry layout for the fetch stage.
package if_pkg;

    localparam int                    DEF_DATA_W   = 32;
    localparam int                    DEF_ADDR_W   = 32;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } q_entry_t;

    // Occupancy counter width: must be able to represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO for the fetch queue; flush wins over push and pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [WIDTH-1:0]        i_data,
    output logic [WIDTH-1:0]        o_data,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        o_full  = (r_count == CW'(DEPTH));
        o_empty = (r_count == '0);
        w_push  = i_push & ~o_full & ~i_flush;
        w_pop   = i_pop & ~o_empty & ~i_flush;
        o_data  = r_mem[r_rd];
        o_count = r_count;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC, one-deep read issue to a 1-cycle imem, and a prefetch queue
// feeding decode over valid/ready. A taken branch flushes everything queued.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    fetch_en,
    input  logic                    br_taken,
    input  logic [ADDR_W-1:0]       br_target,
    output logic                    imem_rd,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [DATA_W-1:0]       imem_data,
    output logic                    inst_valid,
    output logic [DATA_W-1:0]       inst,
    output logic [ADDR_W-1:0]       inst_pc,
    input  logic                    dec_ready,
    output logic [cnt_w(DEPTH)-1:0] q_count
);

    localparam int CW = cnt_w(DEPTH);
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic              r_kill;

    logic [CW-1:0]     w_count;
    logic [OW-1:0]     w_occ;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    entry_t            w_in;
    entry_t            w_head;

    // Space check counts the outstanding read so a returning response always fits;
    // a same-cycle pop deliberately does not free a slot.
    always_comb begin
        w_occ      = {1'b0, w_count} + OW'(r_inflight);
        w_issue    = ~RESET & fetch_en & ~br_taken & (w_occ < OW'(DEPTH));
        w_push     = r_inflight & ~r_kill & ~w_full;
        w_pop      = ~w_empty & dec_ready;
        w_in.pc    = r_fetch_pc;
        w_in.instr = imem_data;
        imem_rd    = w_issue;
        imem_addr  = r_pc;
        inst_valid = ~w_empty;
        inst       = w_head.instr;
        inst_pc    = w_head.pc;
        q_count    = w_count;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc       <= RESET_PC;
            r_fetch_pc <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            // Marks a response that straddles a redirect as stale.
            r_kill     <= br_taken & r_inflight;
            if (br_taken) begin
                r_pc <= br_target;
            end else if (w_issue) begin
                r_pc       <= r_pc + ADDR_W'(PC_STEP);
                r_fetch_pc <= r_pc;
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (br_taken),
        .i_data  (w_in),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
